seq_math_accelerator: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle 8-bit math peripheral on the TinyQV bus. Operands are WIDTH bits wide and loaded byte-wise; MUL and DIV run on an iterative shift-add/restoring engine under a start/busy/done handshake, with divide-by-zero reporting and an optional completion interrupt. Sits behind the standard peripheral port (4-bit address, 8-bit data) in the TinyQV wrapper.

---
 rtl/seq_math_pkg.sv | 48 ++++
 rtl/seq_muldiv_unit.sv | 99 +++++++++
 rtl/seq_math_accelerator.sv | 180 ++++++++++++++++++
 tb/tb_seq_math_accelerator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_math_pkg.sv
// Shared constants for the sequential math accelerator: opcodes, register
// addresses, control/status bit positions and the control FSM state type.
package seq_math_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;

  // Register map
  localparam logic [3:0] ADDR_A_LO   = 4'h0;
  localparam logic [3:0] ADDR_A_HI   = 4'h1;
  localparam logic [3:0] ADDR_B_LO   = 4'h2;
  localparam logic [3:0] ADDR_B_HI   = 4'h3;
  localparam logic [3:0] ADDR_OP     = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h7;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_RES0   = 4'h9;
  localparam logic [3:0] ADDR_RES1   = 4'hA;
  localparam logic [3:0] ADDR_RES2   = 4'hB;
  localparam logic [3:0] ADDR_RES3   = 4'hC;

  // CTRL write bits
  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Opcodes that need the iterative engine
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, WIDTH cycles per operation.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             load operands and begin (ignored while busy)
//   op                OP_DIV selects divide, anything else multiplies
//   a, b              operands (multiplicand/dividend, multiplier/divisor)
//   busy              high while iterating
//   done              combinational strobe during the final iteration cycle
//   result            combinational final value, valid only with done;
//                     divide packs {remainder, quotient}
module seq_muldiv_unit
  import seq_math_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic             is_div_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;

  logic [RW-1:0]    acc_n;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             qbit;
  logic             last;

  // One iteration step for both algorithms; the final step also feeds result
  always_comb begin
    acc_n   = acc_q + (mplier_q[0] ? mcand_q : '0);
    shifted = {rem_q, quo_q[WIDTH-1]};
    qbit    = 1'b0;
    rem_n   = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, dvsr_q}) begin
      qbit  = 1'b1;
      rem_n = WIDTH'(shifted - {1'b0, dvsr_q});
    end
    quo_n = {quo_q[WIDTH-2:0], qbit};
    last  = busy_q && (cnt_q == CW'(WIDTH - 1));
  end

  assign busy   = busy_q;
  assign done   = last;
  assign result = is_div_q ? {rem_n, quo_n} : acc_n;

  // Operand latch and iteration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else if (start && !busy_q) begin
      busy_q   <= 1'b1;
      is_div_q <= (op == OP_DIV);
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= RW'(a);
      mplier_q <= b;
      rem_q    <= '0;
      quo_q    <= a;
      dvsr_q   <= b;
    end else if (busy_q) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      cnt_q    <= cnt_q + CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_math_accelerator.sv
// Byte-addressed math peripheral: operand/opcode registers, single-cycle ALU
// ops, MUL/DIV via the iterative engine, start/busy/done handshake with
// divide-by-zero error and optional completion interrupt.
// Ports:
//   clk, rst          clock, async active-high reset
//   ui_in             input PMOD (unused)
//   uo_out            {busy, done, err, 5'b0}
//   address           register address
//   data_write        one-cycle write strobe
//   data_in           write data
//   data_out          read data, combinational from address
//   user_interrupt    done && irq_en
module seq_math_accelerator
  import seq_math_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          IRQ_DEFAULT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       user_interrupt
);

  localparam int unsigned RW   = 2 * WIDTH;
  localparam bit          WIDE = (WIDTH == 16);

  state_t state_q, state_d;

  logic [15:0]      a_q, b_q;
  logic [3:0]       op_q;
  logic             irq_en_q, irq_en_d;
  logic             err_q;
  logic             irq_q;
  logic [31:0]      result_q;

  logic [WIDTH-1:0] a_op, b_op;
  logic             ctrl_wr, start_req, clr_req;
  logic             div0, iter;
  logic             accept, mdu_start;
  logic [RW-1:0]    alu_res;

  logic             mdu_busy, mdu_done;
  logic [RW-1:0]    mdu_result;

  logic             done_flag;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ui_in};

  assign a_op      = a_q[WIDTH-1:0];
  assign b_op      = b_q[WIDTH-1:0];
  assign ctrl_wr   = data_write && (address == ADDR_CTRL);
  assign start_req = ctrl_wr && data_in[CTRL_START];
  assign clr_req   = ctrl_wr && data_in[CTRL_CLEAR];
  assign div0      = (op_q == OP_DIV) && (b_op == '0);
  assign iter      = is_iterative(op_q) && !div0;
  assign irq_en_d  = ctrl_wr ? data_in[CTRL_IRQ_EN] : irq_en_q;
  assign done_flag = (state_q == S_DONE);

  // Control FSM: start is honoured from IDLE or DONE, and wins over clear
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mdu_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          accept    = 1'b1;
          mdu_start = iter;
          state_d   = iter ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (mdu_done) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_req) begin
          accept    = 1'b1;
          mdu_start = iter;
          state_d   = iter ? S_RUN : S_DONE;
        end else if (clr_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle results on zero-extended operands, modulo 2^(2*WIDTH)
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = RW'(a_op) + RW'(b_op);
      OP_SUB:  alu_res = RW'(a_op) - RW'(b_op);
      OP_AND:  alu_res = RW'(a_op & b_op);
      OP_OR:   alu_res = RW'(a_op | b_op);
      OP_XOR:  alu_res = RW'(a_op ^ b_op);
      OP_DIV:  alu_res = {a_op, {WIDTH{1'b1}}};  // only reached for B == 0
      default: alu_res = '0;
    endcase
  end

  seq_muldiv_unit #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op     (op_q),
    .a      (a_op),
    .b      (b_op),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result)
  );

  // Register file, result capture and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      irq_en_q <= IRQ_DEFAULT;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_en_q <= irq_en_d;
      irq_q    <= (state_d == S_DONE) && irq_en_d;

      if (data_write && (state_q != S_RUN)) begin
        case (address)
          ADDR_A_LO: a_q[7:0]  <= data_in;
          ADDR_A_HI: if (WIDE) a_q[15:8] <= data_in;
          ADDR_B_LO: b_q[7:0]  <= data_in;
          ADDR_B_HI: if (WIDE) b_q[15:8] <= data_in;
          ADDR_OP:   op_q      <= data_in[3:0];
          default: ;
        endcase
      end

      if (accept) begin
        err_q <= div0;
        if (!iter) result_q <= 32'(alu_res);
      end
      if ((state_q == S_RUN) && mdu_done) result_q <= 32'(mdu_result);
    end
  end

  // Read-back mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_A_LO:   data_out = a_q[7:0];
      ADDR_A_HI:   data_out = WIDE ? a_q[15:8] : 8'h00;
      ADDR_B_LO:   data_out = b_q[7:0];
      ADDR_B_HI:   data_out = WIDE ? b_q[15:8] : 8'h00;
      ADDR_OP:     data_out = {4'h0, op_q};
      ADDR_CTRL:   data_out = {5'b0, irq_en_q, 2'b0};
      ADDR_STATUS: data_out = {5'b0, err_q, done_flag, mdu_busy};
      ADDR_RES0:   data_out = result_q[7:0];
      ADDR_RES1:   data_out = result_q[15:8];
      ADDR_RES2:   data_out = WIDE ? result_q[23:16] : 8'h00;
      ADDR_RES3:   data_out = WIDE ? result_q[31:24] : 8'h00;
      default:     data_out = 8'h00;
    endcase
  end

  assign uo_out         = {mdu_busy, done_flag, err_q, 5'b0};
  assign user_interrupt = irq_q;

endmodule

// File: tb/tb_seq_math_accelerator.sv
// Directed bench for seq_math_accelerator at WIDTH=8 and WIDTH=16.
module tb_seq_math_accelerator;

  logic       clk;
  logic       rst8, rst16;
  logic [7:0] ui_in;
  logic [7:0] uo8, uo16;
  logic [3:0] addr8, addr16;
  logic       we8, we16;
  logic [7:0] din8, din16;
  logic [7:0] dout8, dout16;
  logic       irq8, irq16;

  int checks;
  int errors;

  seq_math_accelerator #(.WIDTH(8), .IRQ_DEFAULT(1'b0)) dut8 (
    .clk            (clk),
    .rst            (rst8),
    .ui_in          (ui_in),
    .uo_out         (uo8),
    .address        (addr8),
    .data_write     (we8),
    .data_in        (din8),
    .data_out       (dout8),
    .user_interrupt (irq8)
  );

  seq_math_accelerator #(.WIDTH(16), .IRQ_DEFAULT(1'b1)) dut16 (
    .clk            (clk),
    .rst            (rst16),
    .ui_in          (ui_in),
    .uo_out         (uo16),
    .address        (addr16),
    .data_write     (we16),
    .data_in        (din16),
    .data_out       (dout16),
    .user_interrupt (irq16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input logic [3:0] a, input logic [7:0] d);
    addr8 = a; din8 = d; we8 = 1'b1;
    tick();
    we8 = 1'b0;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [7:0] d);
    addr16 = a; din16 = d; we16 = 1'b1;
    tick();
    we16 = 1'b0;
  endtask

  task automatic rd8(input string tag, input logic [3:0] a, input logic [7:0] exp);
    addr8 = a;
    #1;
    chk(tag, 32'(dout8), 32'(exp));
  endtask

  task automatic rd16(input string tag, input logic [3:0] a, input logic [7:0] exp);
    addr16 = a;
    #1;
    chk(tag, 32'(dout16), 32'(exp));
  endtask

  initial begin
    checks = 0; errors = 0;
    ui_in = 8'h00;
    rst8 = 1'b1; rst16 = 1'b1;
    addr8 = 4'h0; addr16 = 4'h0;
    we8 = 1'b0; we16 = 1'b0;
    din8 = 8'h00; din16 = 8'h00;
    tick(); tick();
    rst8 = 1'b0; rst16 = 1'b0;
    tick();

    // ---------------- WIDTH = 8 ----------------
    chk("w8 reset uo_out", 32'(uo8), 32'h00);
    chk("w8 reset irq", 32'(irq8), 32'h0);
    rd8("w8 reset status", 4'h8, 8'h00);
    rd8("w8 reset ctrl", 4'h7, 8'h00);
    rd8("w8 reset res0", 4'h9, 8'h00);

    // MUL 0xFF*0xFF: busy for 8 cycles, done from N+9
    wr8(4'h0, 8'hFF); wr8(4'h2, 8'hFF); wr8(4'h4, 8'h02);
    wr8(4'h7, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      rd8($sformatf("w8 mul busy c%0d", i), 4'h8, 8'h01);
      chk($sformatf("w8 mul uo c%0d", i), 32'(uo8), 32'h80);
      tick();
    end
    rd8("w8 mul done status", 4'h8, 8'h02);
    chk("w8 mul done uo", 32'(uo8), 32'h40);
    rd8("w8 mul res0", 4'h9, 8'h01);
    rd8("w8 mul res1", 4'hA, 8'hFE);
    chk("w8 mul irq off", 32'(irq8), 32'h0);

    wr8(4'h7, 8'h02);
    rd8("w8 clear status", 4'h8, 8'h00);

    // SUB 3-5 wraps to 0xFFFE in one cycle
    wr8(4'h0, 8'h03); wr8(4'h2, 8'h05); wr8(4'h4, 8'h01);
    wr8(4'h7, 8'h01);
    rd8("w8 sub status", 4'h8, 8'h02);
    rd8("w8 sub res0", 4'h9, 8'hFE);
    rd8("w8 sub res1", 4'hA, 8'hFF);

    // DIV 7/0: quotient all ones, remainder A, err, single cycle
    wr8(4'h0, 8'h07); wr8(4'h2, 8'h00); wr8(4'h4, 8'h03);
    wr8(4'h7, 8'h01);
    rd8("w8 div0 status", 4'h8, 8'h06);
    chk("w8 div0 uo", 32'(uo8), 32'h60);
    rd8("w8 div0 res0", 4'h9, 8'hFF);
    rd8("w8 div0 res1", 4'hA, 8'h07);

    // ADD 7+0 from DONE: start accepted directly, err cleared
    wr8(4'h4, 8'h00);
    wr8(4'h7, 8'h01);
    rd8("w8 add err clr status", 4'h8, 8'h02);
    rd8("w8 add res0", 4'h9, 8'h07);

    // MUL 0x0F*0x0E with writes to A, start and clear while busy
    wr8(4'h0, 8'h0F); wr8(4'h2, 8'h0E); wr8(4'h4, 8'h02);
    wr8(4'h7, 8'h01);      // start in N
    wr8(4'h0, 8'h11);      // N+1: ignored
    wr8(4'h7, 8'h05);      // N+2: start ignored, irq_en honoured
    wr8(4'h7, 8'h06);      // N+3: clear ignored, irq_en stays 1
    rd8("w8 midrun status", 4'h8, 8'h01);
    rd8("w8 midrun A", 4'h0, 8'h0F);
    rd8("w8 midrun ctrl", 4'h7, 8'h04);
    rd8("w8 midrun res hold", 4'h9, 8'h07);
    for (int i = 0; i < 5; i++) tick();
    rd8("w8 midrun done status", 4'h8, 8'h02);
    rd8("w8 midrun res0", 4'h9, 8'hD2);
    rd8("w8 midrun res1", 4'hA, 8'h00);
    chk("w8 midrun irq", 32'(irq8), 32'h1);

    wr8(4'h7, 8'h06);
    chk("w8 clear irq", 32'(irq8), 32'h0);
    rd8("w8 clear2 status", 4'h8, 8'h00);

    // Start and clear together: start wins
    wr8(4'h4, 8'h00);
    wr8(4'h7, 8'h05);
    chk("w8 add irq", 32'(irq8), 32'h1);
    wr8(4'h7, 8'h07);
    rd8("w8 start+clear status", 4'h8, 8'h02);
    rd8("w8 start+clear res0", 4'h9, 8'h1D);
    chk("w8 start+clear irq", 32'(irq8), 32'h1);
    wr8(4'h7, 8'h02);
    rd8("w8 clear3 status", 4'h8, 8'h00);
    chk("w8 clear3 irq", 32'(irq8), 32'h0);

    // Reset asserted in cycle 4 of a MUL
    wr8(4'h0, 8'h80); wr8(4'h2, 8'h80); wr8(4'h4, 8'h02);
    wr8(4'h7, 8'h05);
    tick(); tick(); tick();
    rst8 = 1'b1;
    #1;
    chk("w8 rst uo", 32'(uo8), 32'h00);
    chk("w8 rst irq", 32'(irq8), 32'h0);
    rd8("w8 rst status", 4'h8, 8'h00);
    rd8("w8 rst res0", 4'h9, 8'h00);
    rd8("w8 rst res1", 4'hA, 8'h00);
    rd8("w8 rst A", 4'h0, 8'h00);
    rd8("w8 rst op", 4'h4, 8'h00);
    rd8("w8 rst ctrl", 4'h7, 8'h00);
    tick();
    rst8 = 1'b0;
    tick(); tick();
    rd8("w8 post rst status", 4'h8, 8'h00);
    wr8(4'h0, 8'h80); wr8(4'h2, 8'h80); wr8(4'h4, 8'h00);
    wr8(4'h7, 8'h01);
    rd8("w8 add80 status", 4'h8, 8'h02);
    rd8("w8 add80 res0", 4'h9, 8'h00);
    rd8("w8 add80 res1", 4'hA, 8'h01);

    // Absent high bytes and unmapped addresses
    wr8(4'h1, 8'hAA); wr8(4'h3, 8'hBB); wr8(4'hB, 8'hCC);
    wr8(4'hC, 8'hDD); wr8(4'hF, 8'hEE); wr8(4'h5, 8'h11);
    rd8("w8 rd 0x1", 4'h1, 8'h00);
    rd8("w8 rd 0x3", 4'h3, 8'h00);
    rd8("w8 rd 0xB", 4'hB, 8'h00);
    rd8("w8 rd 0xC", 4'hC, 8'h00);
    rd8("w8 rd 0xF", 4'hF, 8'h00);
    rd8("w8 rd 0x5", 4'h5, 8'h00);
    rd8("w8 rd A kept", 4'h0, 8'h80);
    rd8("w8 rd B kept", 4'h2, 8'h80);

    // ---------------- WIDTH = 16 ----------------
    tick();
    rd16("w16 reset ctrl", 4'h7, 8'h04);
    rd16("w16 reset status", 4'h8, 8'h00);
    chk("w16 reset irq", 32'(irq16), 32'h0);
    chk("w16 reset uo", 32'(uo16), 32'h00);

    // DIV 0xBEEF / 0x0010 with interrupt
    wr16(4'h0, 8'hEF); wr16(4'h1, 8'hBE);
    wr16(4'h2, 8'h10); wr16(4'h3, 8'h00);
    wr16(4'h4, 8'h03);
    wr16(4'h7, 8'h05);
    for (int i = 1; i <= 16; i++) begin
      rd16($sformatf("w16 div busy c%0d", i), 4'h8, 8'h01);
      chk($sformatf("w16 div irq c%0d", i), 32'(irq16), 32'h0);
      tick();
    end
    rd16("w16 div done status", 4'h8, 8'h02);
    chk("w16 div irq", 32'(irq16), 32'h1);
    rd16("w16 div res0", 4'h9, 8'hEE);
    rd16("w16 div res1", 4'hA, 8'h0B);
    rd16("w16 div res2", 4'hB, 8'h0F);
    rd16("w16 div res3", 4'hC, 8'h00);
    tick();
    chk("w16 div irq held", 32'(irq16), 32'h1);
    wr16(4'h7, 8'h06);
    chk("w16 clear irq", 32'(irq16), 32'h0);
    rd16("w16 clear status", 4'h8, 8'h00);

    // MUL 0xFFFF * 0xFFFF, interrupt disabled
    wr16(4'h0, 8'hFF); wr16(4'h1, 8'hFF);
    wr16(4'h2, 8'hFF); wr16(4'h3, 8'hFF);
    wr16(4'h4, 8'h02);
    wr16(4'h7, 8'h01);
    for (int i = 1; i < 16; i++) tick();
    rd16("w16 mul busy c16", 4'h8, 8'h01);
    tick();
    rd16("w16 mul done status", 4'h8, 8'h02);
    rd16("w16 mul res0", 4'h9, 8'h01);
    rd16("w16 mul res1", 4'hA, 8'h00);
    rd16("w16 mul res2", 4'hB, 8'hFE);
    rd16("w16 mul res3", 4'hC, 8'hFF);
    rd16("w16 mul A hi", 4'h1, 8'hFF);
    chk("w16 mul irq off", 32'(irq16), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
